// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forwarding control with saturating perf counters and memory-wait watchdog
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_pc_src,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             memwb_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3;
    logic mStall, loadUse, flushHit, luStall;
    logic [1:0] nextState;
    logic [WW-1:0] waitCnt, waitNext;
    assign mStall   = mem_req & ~mem_ready;
    assign loadUse  = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign flushHit = ~mStall & ex_pc_src;
    assign luStall  = ~mStall & ~ex_pc_src & loadUse;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= nextState;
            stall_cnt   <= ((mStall | luStall) && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt   <= (flushHit && flush_cnt != '1) ? flush_cnt + 1'b1 : flush_cnt;
            waitCnt     <= waitNext;
            mem_timeout <= mem_timeout | (waitNext == WW'(TIMEOUT));
        end
    end
    // waitCnt parks at TIMEOUT so a very long wait cannot wrap it
    always_comb begin
        nextState = mStall ? MEM_WAIT : ex_pc_src ? FLUSH : loadUse ? LU_STALL : RUN;
        waitNext  = !mStall ? '0 : (waitCnt == WW'(TIMEOUT)) ? waitCnt : waitCnt + 1'b1;
    end
    always_comb begin
        pc_en     = ~rst & ~mStall & ~luStall;
        ifid_en   = ~rst & ~mStall & ~luStall;
        ifid_clr  = rst | flushHit;
        idex_en   = ~rst & ~mStall;
        idex_clr  = rst | flushHit | luStall;
        exmem_en  = ~rst & ~mStall;
        exmem_clr = rst;
        memwb_en  = ~rst;
        memwb_clr = rst | mStall;
        fwd_a     = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                    (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
        fwd_b     = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                    (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus multi-cycle sequences for hazard_ctrl
module tb_hazard_ctrl;
    localparam int CNT_W = 3;
    localparam logic [8:0] C_NORM = 9'b110101010;
    localparam logic [8:0] C_MST  = 9'b000000011;
    localparam logic [8:0] C_FLU  = 9'b111111010;
    localparam logic [8:0] C_LU   = 9'b000111010;
    localparam logic [8:0] C_RST  = 9'b001010101;
    localparam logic [1:0] RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3;

    logic clk = 1'b0, rst;
    logic [4:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
    logic exMemRead, exPcSrc, memRegWrite, wbRegWrite, memReq, memReady;
    logic pcEn, ifidEn, ifidClr, idexEn, idexClr, exmemEn, exmemClr, memwbEn, memwbClr, memTimeout;
    logic [1:0] fwdA, fwdB, st;
    logic [CNT_W-1:0] stallCnt, flushCnt;
    logic [8:0] ctrl;
    int nCmp = 0, nBad = 0;

    assign ctrl = {pcEn, ifidEn, ifidClr, idexEn, idexClr, exmemEn, exmemClr, memwbEn, memwbClr};
    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .id_rs1(idRs1), .id_rs2(idRs2), .ex_rs1(exRs1), .ex_rs2(exRs2),
        .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_pc_src(exPcSrc), .mem_rd(memRd), .wb_rd(wbRd),
        .mem_reg_write(memRegWrite), .wb_reg_write(wbRegWrite), .mem_req(memReq), .mem_ready(memReady),
        .pc_en(pcEn), .ifid_en(ifidEn), .ifid_clr(ifidClr), .idex_en(idexEn), .idex_clr(idexClr),
        .exmem_en(exmemEn), .exmem_clr(exmemClr), .memwb_en(memwbEn), .memwb_clr(memwbClr),
        .fwd_a(fwdA), .fwd_b(fwdB), .state(st), .stall_cnt(stallCnt), .flush_cnt(flushCnt),
        .mem_timeout(memTimeout)
    );

    typedef struct {
        logic [4:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
        logic exMemRead, exPcSrc, memRegWrite, wbRegWrite, memReq, memReady;
        logic [8:0] ctrl;
        logic [1:0] fwdA, fwdB, st;
        int sInc, fInc;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] a, b, c, d, e, input logic mr, ps,
                                input logic [4:0] mrd, wrd, input logic mw, ww, rq, rdy,
                                input logic [8:0] ct, input logic [1:0] fa, fb, s, input int si, fi);
        vec_t v;
        v.idRs1 = a; v.idRs2 = b; v.exRs1 = c; v.exRs2 = d; v.exRd = e;
        v.exMemRead = mr; v.exPcSrc = ps; v.memRd = mrd; v.wbRd = wrd;
        v.memRegWrite = mw; v.wbRegWrite = ww; v.memReq = rq; v.memReady = rdy;
        v.ctrl = ct; v.fwdA = fa; v.fwdB = fb; v.st = s; v.sInc = si; v.fInc = fi;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        {idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd} = '0;
        {exMemRead, exPcSrc, memRegWrite, wbRegWrite, memReq, memReady} = '0;
    endtask

    task automatic resetDut();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // one cycle of memory wait (or release) with control and post-edge state checks
    task automatic memCycle(input string tag, input logic rdy, input logic [8:0] expCtrl, input logic [1:0] expSt);
        memReq = 1'b1; memReady = rdy;
        #1 check({tag, " ctrl"}, 16'(ctrl), 16'(expCtrl));
        @(posedge clk); #1;
        check({tag, " state"}, 16'(st), 16'(expSt));
    endtask

    vec_t vecs[12];
    int expStall, expFlush;

    initial begin
        idle();
        rst = 1'b1;
        #1 check("reset ctrl", 16'(ctrl), 16'(C_RST));
        @(posedge clk); #1;
        check("reset state", 16'(st), 16'(RUN));
        check("reset stall_cnt", 16'(stallCnt), 16'd0);
        check("reset flush_cnt", 16'(flushCnt), 16'd0);
        check("reset timeout", 16'(memTimeout), 16'd0);
        rst = 1'b0;

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00, RUN, 0, 0);
        vecs[1]  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, C_LU, 2'b00, 2'b00, LU_STALL, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00, RUN, 0, 0);
        vecs[3]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00, RUN, 0, 0);
        vecs[4]  = mk(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, C_FLU, 2'b00, 2'b00, FLUSH, 0, 1);
        vecs[5]  = mk(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, C_MST, 2'b00, 2'b00, MEM_WAIT, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 2'b00, 2'b00, RUN, 0, 0);
        vecs[7]  = mk(0, 0, 7, 7, 0, 0, 0, 7, 7, 1, 1, 0, 0, C_NORM, 2'b10, 2'b10, RUN, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_NORM, 2'b00, 2'b00, RUN, 0, 0);
        vecs[9]  = mk(0, 0, 7, 3, 0, 0, 0, 7, 7, 0, 1, 0, 0, C_NORM, 2'b01, 2'b00, RUN, 0, 0);
        vecs[10] = mk(0, 0, 9, 4, 0, 0, 0, 4, 9, 1, 1, 0, 0, C_NORM, 2'b01, 2'b10, RUN, 0, 0);
        vecs[11] = mk(12, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, C_LU, 2'b00, 2'b00, LU_STALL, 1, 0);

        expStall = 0; expFlush = 0;
        for (int i = 0; i < 12; i++) begin
            idRs1 = vecs[i].idRs1; idRs2 = vecs[i].idRs2; exRs1 = vecs[i].exRs1; exRs2 = vecs[i].exRs2;
            exRd = vecs[i].exRd; exMemRead = vecs[i].exMemRead; exPcSrc = vecs[i].exPcSrc;
            memRd = vecs[i].memRd; wbRd = vecs[i].wbRd; memRegWrite = vecs[i].memRegWrite;
            wbRegWrite = vecs[i].wbRegWrite; memReq = vecs[i].memReq; memReady = vecs[i].memReady;
            #1;
            check($sformatf("vec%0d ctrl", i), 16'(ctrl), 16'(vecs[i].ctrl));
            check($sformatf("vec%0d fwd_a", i), 16'(fwdA), 16'(vecs[i].fwdA));
            check($sformatf("vec%0d fwd_b", i), 16'(fwdB), 16'(vecs[i].fwdB));
            @(posedge clk); #1;
            expStall += vecs[i].sInc;
            expFlush += vecs[i].fInc;
            check($sformatf("vec%0d state", i), 16'(st), 16'(vecs[i].st));
            check($sformatf("vec%0d stall_cnt", i), 16'(stallCnt), 16'(expStall));
            check($sformatf("vec%0d flush_cnt", i), 16'(flushCnt), 16'(expFlush));
        end

        // three-cycle memory wait then release
        resetDut();
        for (int k = 0; k < 3; k++) memCycle($sformatf("wait3 c%0d", k), 1'b0, C_MST, MEM_WAIT);
        memCycle("wait3 release", 1'b1, C_NORM, RUN);
        check("wait3 stall_cnt", 16'(stallCnt), 16'd3);
        check("wait3 timeout", 16'(memTimeout), 16'd0);

        // six-cycle wait crosses the 4-cycle watchdog; flag is sticky
        resetDut();
        for (int k = 1; k <= 6; k++) begin
            memCycle($sformatf("wait6 c%0d", k), 1'b0, C_MST, MEM_WAIT);
            check($sformatf("wait6 timeout c%0d", k), 16'(memTimeout), 16'(k >= 4));
        end
        memCycle("wait6 release", 1'b1, C_NORM, RUN);
        check("wait6 timeout sticky", 16'(memTimeout), 16'd1);
        check("wait6 stall_cnt", 16'(stallCnt), 16'd6);
        for (int k = 0; k < 2; k++) memCycle($sformatf("sat c%0d", k), 1'b0, C_MST, MEM_WAIT);
        check("stall_cnt saturate", 16'(stallCnt), 16'd7);

        // reset in the middle of a memory wait
        rst = 1'b1;
        #1 check("midwait rst ctrl", 16'(ctrl), 16'(C_RST));
        @(posedge clk); #1;
        rst = 1'b0;
        check("midwait rst state", 16'(st), 16'(RUN));
        check("midwait rst stall_cnt", 16'(stallCnt), 16'd0);
        check("midwait rst timeout", 16'(memTimeout), 16'd0);
        idle();

        // flush counter saturation
        exPcSrc = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("flush_cnt saturate", 16'(flushCnt), 16'd7);
        check("flush state", 16'(st), 16'(FLUSH));
        check("flush stall_cnt", 16'(stallCnt), 16'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
